mem_arbiter: RTL and testbench

- Owns the single byte-wide RAM/IO port. Shares it between the instruction cache (4-byte fetches) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into byte transfers and reassembles read data little-endian.
- Applies sign or zero extension to loads.
- Honours io_buffer_full for I/O writes and aborts speculative reads on pipeline flush.

---
 rtl/mem_pkg.sv | 17 +
 rtl/ld_extend.sv | 10 +
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and helpers for the byte-wide memory port arbiter
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] IO_REGION = 2'b11;

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    function automatic logic is_io(input logic [31:0] a, input int hi);
        return 2'(a >> (hi - 1)) == IO_REGION;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/ld_extend.sv
// ld_extend: zero/sign extension of byte and half loads, words pass through
module ld_extend import mem_pkg::*; (
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] raw,
    output logic [31:0] ext
);
    assign ext = size == SZ_BYTE ? {{24{sgn & raw[7]}}, raw[7:0]} :
                 size == SZ_HALF ? {{16{sgn & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between icache fetches and LSB loads/stores
module mem_arbiter import mem_pkg::*; #(
    parameter int ADDR_W     = 32,
    parameter int IO_MASK_HI = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic              ls_signed,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d, n_q, n_d, k;
    logic [1:0] j, size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
    logic [31:0] wdata_q, wdata_d, rbuf_q, rbuf_d, if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
    logic [31:0] cap, ext;
    logic [7:0] mem_dout_q, mem_dout_d;
    logic sgn_q, sgn_d, mem_wr_q, mem_wr_d, if_done_q, if_done_d, ls_done_q, ls_done_d, stall;

    // k is the index of the edge about to happen; j is the byte slot that edge captures
    assign k = cnt_q + 3'd1;
    assign j = 2'(cnt_q - 3'd1);
    assign stall = state_q == LS_WR && is_io(32'(mem_a_q), IO_MASK_HI) && io_buffer_full;

    ld_extend u_ext (.size(size_q), .sgn(sgn_q), .raw(cap), .ext(ext));

    // read buffer with the byte arriving this cycle merged in
    always_comb begin
        cap = rbuf_q;
        if (cnt_q != 3'd0) cap[8*j +: 8] = mem_din;
    end

    // arbitration and byte sequencing for fetch, load and store
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            IDLE: if (!if_done_q && !ls_done_q && !flush && (ls_req || if_req)) begin
                addr_d     = ls_req ? ls_addr : if_addr;
                n_d        = ls_req ? size_bytes(ls_size) : 3'd4;
                wdata_d    = ls_wdata;
                size_d     = ls_size;
                sgn_d      = ls_signed;
                mem_a_d    = addr_d;
                cnt_d      = '0;
                rbuf_d     = '0;
                mem_wr_d   = ls_req && ls_wr;
                mem_dout_d = ls_req && ls_wr ? ls_wdata[7:0] : mem_dout_q;
                state_d    = !ls_req ? IF_RD : ls_wr ? LS_WR : LS_RD;
            end
            IF_RD, LS_RD: if (flush) begin
                state_d = IDLE;
                mem_a_d = '0;
                cnt_d   = '0;
            end else begin
                rbuf_d = cap;
                if (k < n_q) mem_a_d = addr_q + ADDR_W'(k);
                if (cnt_q == n_q) begin
                    state_d    = IDLE;
                    mem_a_d    = '0;
                    cnt_d      = '0;
                    if_done_d  = state_q == IF_RD;
                    ls_done_d  = state_q == LS_RD;
                    if_data_d  = state_q == IF_RD ? cap : if_data_q;
                    ls_rdata_d = state_q == LS_RD ? ext : ls_rdata_q;
                end else begin
                    cnt_d = k;
                end
            end
            LS_WR: if (!stall) begin
                if (k < n_q) begin
                    mem_a_d    = addr_q + ADDR_W'(k);
                    mem_dout_d = wdata_q[8*k[1:0] +: 8];
                    cnt_d      = k;
                end else begin
                    state_d   = IDLE;
                    mem_wr_d  = 1'b0;
                    mem_a_d   = '0;
                    cnt_d     = '0;
                    ls_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // state register; rdy low freezes everything including pending done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q && !stall;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions against a byte-array memory model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1, rdy = 1'b1, flush = 1'b0, io_buffer_full = 1'b0;
    logic if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0, ls_signed = 1'b0;
    logic [1:0] ls_size = 2'd0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [7:0] mem_din = '0;
    logic [7:0] mem_dout;
    logic [31:0] mem_a, if_data, ls_rdata;
    logic mem_wr, if_done, ls_done;

    bit [7:0] ram [0:65535];
    bit [7:0] mdl [0:65535];
    int io_wr = 0, wr_cnt = 0;
    int checks = 0, failures = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_signed(ls_signed),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    // synchronous RAM sharing the system enable; I/O-region writes are only counted
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) begin
                wr_cnt <= wr_cnt + 1;
                if (mem_a[17:16] == 2'b11) io_wr <= io_wr + 1;
                else ram[mem_a[15:0]] <= mem_dout;
            end
            mem_din <= ram[mem_a[15:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ld(input logic [31:0] a, input int n, input bit sgn);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[16'(a + 32'(i))]) << (8 * i);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    // ev: 0 none, 1 rdy low for two cycles after edge ev_at, 2 one-cycle flush after edge ev_at
    task automatic xact(input bit ls, input bit wr, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] a, input logic [31:0] wd, input int ev, input int ev_at);
        int n, lat, e, exp_lat;
        bit done;
        logic [31:0] held;
        n = !ls ? 4 : sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        if (ls) begin
            ls_req = 1'b1; ls_wr = wr; ls_size = sz; ls_signed = sgn; ls_addr = a; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        lat = 0; e = -1; done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++; e++;
            if (ev == 2 && e == ev_at + 1) flush = 1'b0;
            if (e < n) begin
                chk("addr", mem_a, a + 32'(e));
                chk("wr", 32'(mem_wr), 32'(wr));
                if (wr) chk("dout", 32'(mem_dout), 32'(8'(wd >> (8 * e))));
            end
            done = ls ? ls_done : if_done;
            if (ev == 1 && e == ev_at) begin
                held = mem_a;
                rdy = 1'b0;
                repeat (2) @(posedge clk);
                #1 rdy = 1'b1;
                lat += 2;
                chk("hold_addr", mem_a, held);
            end
            if (ev == 2 && e == ev_at) flush = 1'b1;
        end
        flush = 1'b0; ls_req = 1'b0; if_req = 1'b0;
        exp_lat = n + (wr ? 1 : 2) + (ev == 1 ? 2 : 0);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("idle_addr", mem_a, 32'h0);
        chk("other_done", 32'(ls ? if_done : ls_done), 32'h0);
        if (wr) for (int i = 0; i < n; i++) mdl[16'(a + 32'(i))] = 8'(wd >> (8 * i));
        else chk(ls ? "ls_rdata" : "if_data", ls ? ls_rdata : if_data, ref_ld(a, n, ls && sgn));
        @(posedge clk); #1;
        chk("pulse", {30'b0, if_done, ls_done}, 32'h0);
    endtask

    initial begin
        int lat, base;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_a", mem_a, 0);
        chk("rst_dout", 32'(mem_dout), 0);
        chk("rst_wr", 32'(mem_wr), 0);
        chk("rst_ifd", 32'(if_done), 0);
        chk("rst_lsd", 32'(ls_done), 0);
        chk("rst_ifdata", if_data, 0);
        chk("rst_lsdata", ls_rdata, 0);

        xact(1, 1, 2'd2, 0, 32'h100, 32'h0000_0513, 0, 0);
        xact(1, 1, 2'd0, 0, 32'h200, 32'h0000_0080, 0, 0);
        xact(0, 0, 2'd2, 0, 32'h100, 32'h0, 0, 0);
        chk("fetch_word", if_data, 32'h0000_0513);

        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_signed = 1'b1; ls_addr = 32'h200;
        lat = 0;
        while (!ls_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            chk("prio_ifd", 32'(if_done), 0);
        end
        chk("prio_lat", 32'(lat), 3);
        chk("prio_lb", ls_rdata, 32'hFFFF_FF80);
        ls_req = 1'b0;
        lat = 0;
        while (!if_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bubble_lat", 32'(lat), 7);
        chk("bubble_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        @(posedge clk); #1;

        base = wr_cnt;
        xact(1, 1, 2'd2, 0, 32'h300, 32'hDEAD_BEEF, 0, 0);
        chk("sw_cycles", 32'(wr_cnt - base), 4);
        xact(1, 0, 2'd1, 0, 32'h302, 32'h0, 0, 0);
        chk("lh_u", ls_rdata, 32'h0000_DEAD);

        base = io_wr;
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h3_0000; ls_wdata = 32'h41;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_wr", 32'(mem_wr), 0);
            chk("stall_done", 32'(ls_done), 0);
        end
        io_buffer_full = 1'b0;
        #1;
        chk("io_wr", 32'(mem_wr), 1);
        chk("io_a", mem_a, 32'h3_0000);
        chk("io_dout", 32'(mem_dout), 32'h41);
        @(posedge clk); #1;
        ls_req = 1'b0;
        chk("io_done", 32'(ls_done), 1);
        chk("io_once", 32'(io_wr - base), 1);
        @(posedge clk); #1;

        if_req = 1'b1; if_addr = 32'h100;
        repeat (2) @(posedge clk);
        #1 flush = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_a", mem_a, 0);
        repeat (5) begin
            chk("flush_ifd", 32'(if_done), 0);
            @(posedge clk); #1;
        end

        xact(1, 1, 2'd2, 0, 32'h400, 32'h1122_3344, 2, 1);
        xact(1, 0, 2'd2, 0, 32'h400, 32'h0, 0, 0);
        chk("flush_sw", ls_rdata, 32'h1122_3344);
        xact(1, 0, 2'd2, 0, 32'h300, 32'h0, 1, 2);
        chk("rdy_lw", ls_rdata, 32'hDEAD_BEEF);
        xact(0, 0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0, 0, 0);

        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_a", mem_a, 0);
        chk("mrst_dout", 32'(mem_dout), 0);
        chk("mrst_wr", 32'(mem_wr), 0);
        chk("mrst_ifd", 32'(if_done), 0);
        chk("mrst_lsd", 32'(ls_done), 0);
        chk("mrst_ifdata", if_data, 0);
        chk("mrst_lsdata", ls_rdata, 0);
        rst = 1'b0; ls_req = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("mrst_nodone", 32'(ls_done), 0);
        end
        mdl[16'h500] = 8'h0D;
        mdl[16'h501] = 8'hF0;
        xact(1, 0, 2'd2, 0, 32'h500, 32'h0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int op, ev;
            logic [31:0] a, wd;
            logic [1:0] sz;
            bit sg;
            op = $urandom_range(0, 2);
            a = 32'h1000 + 32'($urandom_range(0, 255));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            ev = (op != 2 && $urandom_range(0, 3) == 0) ? 1 : 0;
            if (op == 0) xact(0, 0, 2'd2, 0, a, 32'h0, ev, $urandom_range(0, 1));
            else if (op == 1) xact(1, 0, sz, sg, a, 32'h0, ev, $urandom_range(0, 1));
            else xact(1, 1, sz, 0, a, wd, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
